// File: rtl/dna_score_max_tracker.sv
// rtl/dna_score_max_tracker.sv - max score/cell tracker behind the last PE of the systolic array
module dna_score_max_tracker #(
   parameter int SCORE_W = 32,
   parameter int IDX_W   = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic               start,
   input  logic               abort,
   input  logic [IDX_W-1:0]   cfg_fill,
   input  logic [IDX_W-1:0]   cfg_cols,
   input  logic [IDX_W-1:0]   cfg_rows,
   input  logic [SCORE_W-1:0] score_i,
   output logic [SCORE_W-1:0] max_score,
   output logic [IDX_W-1:0]   max_row,
   output logic [IDX_W-1:0]   max_col,
   output logic               busy,
   output logic               done,
   output logic               cfg_err
);

   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   fill_cnt, fill_cnt_nxt;
   logic [IDX_W-1:0]   row, row_nxt;
   logic [IDX_W-1:0]   col, col_nxt;
   logic [IDX_W-1:0]   fill_q, fill_q_nxt;
   logic [IDX_W-1:0]   cols_q, cols_q_nxt;
   logic [IDX_W-1:0]   rows_q, rows_q_nxt;
   logic [SCORE_W-1:0] max_score_nxt;
   logic [IDX_W-1:0]   max_row_nxt, max_col_nxt;
   logic               busy_nxt, done_nxt, cfg_err_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         fill_cnt  <= '0;
         row       <= '0;
         col       <= '0;
         fill_q    <= '0;
         cols_q    <= '0;
         rows_q    <= '0;
         max_score <= '0;
         max_row   <= '0;
         max_col   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         fill_cnt  <= fill_cnt_nxt;
         row       <= row_nxt;
         col       <= col_nxt;
         fill_q    <= fill_q_nxt;
         cols_q    <= cols_q_nxt;
         rows_q    <= rows_q_nxt;
         max_score <= max_score_nxt;
         max_row   <= max_row_nxt;
         max_col   <= max_col_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         cfg_err   <= cfg_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      fill_cnt_nxt  = fill_cnt;
      row_nxt       = row;
      col_nxt       = col;
      fill_q_nxt    = fill_q;
      cols_q_nxt    = cols_q;
      rows_q_nxt    = rows_q;
      max_score_nxt = max_score;
      max_row_nxt   = max_row;
      max_col_nxt   = max_col;
      done_nxt      = 1'b0;
      cfg_err_nxt   = cfg_err;

      // abort wins over start and en_i; the maximum found so far is kept
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  max_score_nxt = '0;
                  max_row_nxt   = '0;
                  max_col_nxt   = '0;
                  cfg_err_nxt   = 1'b0;
                  fill_q_nxt    = cfg_fill;
                  cols_q_nxt    = cfg_cols;
                  rows_q_nxt    = cfg_rows;
                  fill_cnt_nxt  = '0;
                  row_nxt       = '0;
                  col_nxt       = '0;
                  if (cfg_cols == '0 || cfg_rows == '0) begin
                     cfg_err_nxt = 1'b1;
                     done_nxt    = 1'b1;
                  end else if (cfg_fill == '0) begin
                     state_nxt = RUN;
                  end else begin
                     state_nxt = FILL;
                  end
               end
            end
            FILL: begin
               if (en_i) begin
                  fill_cnt_nxt = fill_cnt + IDX_ONE;
                  if (fill_cnt == fill_q - IDX_ONE) begin
                     state_nxt = RUN;
                  end
               end
            end
            RUN: begin
               if (en_i) begin
                  // strict compare keeps the earliest cell on ties
                  if (score_i > max_score) begin
                     max_score_nxt = score_i;
                     max_row_nxt   = row;
                     max_col_nxt   = col;
                  end
                  if (col == cols_q - IDX_ONE) begin
                     col_nxt = '0;
                     row_nxt = row + IDX_ONE;
                     if (row == rows_q - IDX_ONE) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                     end
                  end else begin
                     col_nxt = col + IDX_ONE;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: doc/dna_score_max_tracker.md
# dna_score_max_tracker

Downstream stage of the DNA systolic PE array. It samples the score stream leaving the last PE, one score per enabled cycle. It tracks the maximum local-alignment score and the (row, col) cell that produced it, and signals completion once a programmed rows × cols matrix has been consumed. It also discards a programmable number of pipeline-fill cycles before the first valid cell.

## Interface
Parameters:
- SCORE_W, 32, width of the score stream and the maximum register
- IDX_W, 10, width of the row/col counters and configuration fields

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en_i  in  1  array advance enable; the same signal that drives the PEs' en_i
- start  in  1  one-cycle pulse; begins a new scan
- abort  in  1  synchronous abort; returns to IDLE
- cfg_fill  in  IDX_W  number of enabled cycles to discard before cell (0,0)
- cfg_cols  in  IDX_W  cells per row
- cfg_rows  in  IDX_W  number of rows
- score_i  in  SCORE_W  score from the last PE's score_o
- max_score  out  SCORE_W  running or final maximum
- max_row  out  IDX_W  row of max_score
- max_col  out  IDX_W  col of max_score
- busy  out  1  high in FILL and RUN
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  sticky; set when a start arrives with cfg_cols==0 or cfg_rows==0

## Operation
- States: IDLE, FILL, RUN.
- Configuration is latched on the accepted start. Later cfg_* changes do not affect a scan in progress.
- Reset values: state IDLE; all counters 0; max_score, max_row, max_col 0; busy, done, cfg_err 0.
- IDLE + start:
  - Clear max_score/max_row/max_col to 0 and clear cfg_err.
  - If cfg_cols==0 or cfg_rows==0: set cfg_err, pulse done next cycle, stay in IDLE.
  - Else if cfg_fill==0: go to RUN.
  - Else: go to FILL with fill_cnt=0.
- start is ignored while busy.
- FILL: each cycle with en_i high increments fill_cnt. On the en_i cycle where fill_cnt==cfg_fill-1, go to RUN. Cycles with en_i low change nothing.
- RUN: each cycle with en_i high samples score_i for cell (row, col).
  - Update rule: if score_i > max_score (unsigned, strictly greater), load max_score=score_i, max_row=row, max_col=col. Ties keep the earlier cell in row-major order.
  - Index advance: if col==cols-1, set col=0 and row=row+1; otherwise col=col+1.
  - Last cell: on the en_i sample at row==rows-1, col==cols-1, apply the update rule, go to IDLE, and pulse done.
- abort has priority over start and en_i in every state. It forces IDLE, clears busy, gives no done pulse, and holds max_* at their current values.
- en_i low in RUN freezes the counters and the maximum.

## Timing
- All outputs are registered.
- max_* reflect a sample one clock after the en_i edge that captured it.
- done rises in the clock after the last-cell sample edge, lasts exactly one cycle, and max_* are final in that same cycle.
- busy rises the cycle after the accepted start and falls in the same cycle done rises.
- Latency from start to done with en_i held high: 1 + cfg_fill + rows·cols cycles.
- A start asserted in the same cycle as done is accepted (state is IDLE by then).
- An asynchronous rst mid-scan returns every output to its reset value immediately.

## Test plan
- Basic max: cfg_fill=0, cols=4, rows=2, en_i held high, scores 3,7,2,7,1,9,9,0 → max_score=9, max_row=1, max_col=1; done exactly 9 cycles after start.
- Fill discard: cfg_fill=3, cols=2, rows=1, scores 50,50,50,4,6 → the 50s are ignored; max_score=6, row=0, col=1.
- Stalls: same as the basic case with en_i low on alternate cycles → identical result; done delayed by the number of stall cycles.
- Config error: start with cols=0 → cfg_err=1, done pulses the next cycle, busy never rises. A subsequent valid start clears cfg_err.
- Abort/reset: abort after 3 RUN samples → no done, busy=0, max_* retain the partial maximum; rst asserted mid-RUN → all outputs 0 asynchronously.
- Back-to-back: start in the done cycle → new scan runs and the max is cleared; all-zero scores → max_score=0 at row 0, col 0.
